// File: rtl/taps_serializer.sv
// Parallel-in, element-serial-out unloader for the wavelet tap line.
// Captures a full tap vector in one cycle and emits it MSB element first at a divided pace.
module taps_serializer #(
  parameter int unsigned COUNTER_WIDTH = 25,
  parameter int unsigned TOTAL_TAPS    = 9,
  parameter int unsigned BITS_PER_TAP  = 8,
  parameter int unsigned TOTAL_BITS    = TOTAL_TAPS * BITS_PER_TAP
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load,
  input  logic [TOTAL_BITS-1:0]   i_taps,
  output logic                    o_ready,
  output logic                    o_busy,
  output logic [BITS_PER_TAP-1:0] o_value,
  output logic                    o_valid,
  output logic                    o_last,
  output logic                    o_LED
);

  localparam int unsigned IdxW = $clog2(TOTAL_TAPS + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(TOTAL_TAPS - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e                   state_q, state_d;
  logic [TOTAL_BITS-1:0]    sr_q, sr_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [BITS_PER_TAP-1:0]  value_q, value_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    value_d = value_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (i_load) begin
          sr_d    = i_taps;
          idx_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        cnt_d = cnt_q + COUNTER_WIDTH'(1);
        // Emit on the all-ones edge so the counter wraps to zero for the next period.
        if (cnt_q == '1) begin
          value_d = sr_q[TOTAL_BITS-1 -: BITS_PER_TAP];
          sr_d    = sr_q << BITS_PER_TAP;
          valid_d = 1'b1;
          last_d  = (idx_q == LastIdx);
          idx_d   = idx_q + IdxW'(1);
          if (idx_q == LastIdx) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign o_ready = (state_q == StIdle);
  assign o_busy  = (state_q == StShift);
  assign o_value = value_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_LED   = o_busy & ~cnt_q[COUNTER_WIDTH-1];

endmodule

// File: tb/tb_taps_serializer.sv
// Directed bench for taps_serializer with a 4-cycle emit period (COUNTER_WIDTH = 2).
module tb_taps_serializer;

  localparam int unsigned CW = 2;
  localparam logic [71:0] V1 = 72'h010203040506070809;
  localparam logic [71:0] VA = 72'hA1A2A3A4A5A6A7A8A9;
  localparam logic [71:0] VC = 72'h111213141516171819;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [71:0] taps;
  logic        ready, busy, valid, last, led;
  logic [7:0]  value;

  taps_serializer #(
    .COUNTER_WIDTH(CW),
    .TOTAL_TAPS   (9),
    .BITS_PER_TAP (8),
    .TOTAL_BITS   (72)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_load (load),
    .i_taps (taps),
    .o_ready(ready),
    .o_busy (busy),
    .o_value(value),
    .o_valid(valid),
    .o_last (last),
    .o_LED  (led)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  vals[$];
  int          stamps[$];
  bit          lasts[$];
  logic [71:0] tap_line = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream tap shift line consuming every pulse at the emit pace.
  always @(posedge clk) if (valid) tap_line <= {tap_line[63:0], value};

  always @(negedge clk) begin
    if (valid) begin
      vals.push_back(value);
      stamps.push_back(cyc);
      lasts.push_back(last);
    end
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Caller is at a negedge; returns just after the accepting edge.
  task automatic do_load(input logic [71:0] v, output int e0);
    load = 1'b1;
    taps = v;
    @(posedge clk);
    #1;
    e0   = cyc;
    load = 1'b0;
    taps = 72'h5A5A5A5A5A5A5A5A5A;
  endtask

  task automatic check_seq(input logic [71:0] v, input int e0, input int offset);
    logic [71:0] vv;
    vv = v;
    for (int k = 0; k < 9; k++) begin
      if (offset + k < vals.size()) begin
        check($sformatf("val%0d", k), 72'(vals[offset+k]), 72'(vv[71-8*k -: 8]));
        check($sformatf("time%0d", k), 72'(stamps[offset+k] - e0), 72'(4 * (k + 1)));
        check($sformatf("last%0d", k), 72'(lasts[offset+k]), 72'(k == 8));
      end
    end
  endtask

  int e0, e0b;

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    taps  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 72'(ready), 72'd1);
    check("rst_busy",  72'(busy),  72'd0);
    check("rst_value", 72'(value), 72'd0);
    check("rst_valid", 72'(valid), 72'd0);
    check("rst_led",   72'(led),   72'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic vector, ignored load mid-run, back-to-back reload in the last cycle.
    do_load(V1, e0);
    wait_cyc(e0 + 1);
    check("busy",     72'(busy),  72'd1);
    check("not_rdy",  72'(ready), 72'd0);
    check("led_on",   72'(led),   72'd1);
    wait_cyc(e0 + 2);
    check("led_off",  72'(led),   72'd0);
    wait_cyc(e0 + 10);
    load = 1'b1;
    taps = '1;
    @(negedge clk);
    load = 1'b0;
    wait_cyc(e0 + 36);
    check("end_ready", 72'(ready), 72'd1);
    check("end_valid", 72'(valid), 72'd1);
    check("end_last",  72'(last),  72'd1);
    check("end_value", 72'(value), 72'h09);
    do_load(VA, e0b);
    check("b2b_edge", 72'(e0b - e0), 72'd37);
    wait_cyc(e0b);
    check("loop1", tap_line, V1);
    wait_cyc(e0b + 40);
    check("count18", 72'(vals.size()), 72'd18);
    check_seq(V1, e0, 0);
    check_seq(VA, e0b, 9);
    check("loop2",     tap_line,       VA);
    check("idle_rdy",  72'(ready),     72'd1);
    check("idle_busy", 72'(busy),      72'd0);
    check("idle_hold", 72'(value),     72'hA9);

    // Abort after the third element with an asynchronous reset.
    vals.delete();
    stamps.delete();
    lasts.delete();
    do_load(V1, e0);
    wait_cyc(e0 + 12);
    check("abort_v3", 72'(value), 72'h03);
    wait_cyc(e0 + 13);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 72'(ready), 72'd1);
    check("arst_busy",  72'(busy),  72'd0);
    check("arst_value", 72'(value), 72'd0);
    check("arst_valid", 72'(valid), 72'd0);
    check("arst_led",   72'(led),   72'd0);
    repeat (10) @(negedge clk);
    check("abort_cnt", 72'(vals.size()), 72'd3);
    rst_n = 1'b1;
    do_load(VC, e0);
    wait_cyc(e0 + 40);
    check("count12", 72'(vals.size()), 72'd12);
    check_seq(VC, e0, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/taps_serializer.md
# taps_serializer

Parallel-in, element-serial-out unloader for the wavelet tap line: captures a full TOTAL_BITS tap vector in one cycle and emits it one BITS_PER_TAP element at a time at a divided-clock pace. Elements are emitted oldest-first (MSB element first), so streaming the output into the tap shift line reproduces the captured vector exactly. It sits between the filter/tap storage and any downstream element-serial consumer (loopback, debug port, next filter stage).

## Interface
- COUNTER_WIDTH, 25: pacing divider width; one element emitted every 2^COUNTER_WIDTH cycles
- TOTAL_TAPS, 9: elements per vector
- BITS_PER_TAP, 8: element width
- TOTAL_BITS, 9*8: vector width; must equal TOTAL_TAPS*BITS_PER_TAP
- i_clk  in  1  single clock; all state on rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low; the only reset
- i_load  in  1  request to capture i_taps; honoured only when o_ready is high
- i_taps  in  TOTAL_BITS  vector to serialize; element k at bits [TOTAL_BITS-1-k*BITS_PER_TAP -: BITS_PER_TAP], k=0 emitted first
- o_ready  out  1  high in IDLE (and in the cycle showing the last element); load acceptance window
- o_busy  out  1  high in SHIFT
- o_value  out  BITS_PER_TAP  current/most recent emitted element, registered, held between pulses
- o_valid  out  1  one-cycle pulse per emitted element
- o_last  out  1  high with o_valid on element TOTAL_TAPS-1 only
- o_LED  out  1  o_busy AND NOT pacing_counter[COUNTER_WIDTH-1] (blinks while shifting, off idle)

## Operation
- States: IDLE, SHIFT. Internal: shift register sr[TOTAL_BITS], pacing counter cnt[COUNTER_WIDTH], element index idx (clog2(TOTAL_TAPS+1) bits).
- Reset (async, i_rst_n low): state IDLE; sr, cnt, idx = 0; o_value = 0; o_valid = o_last = 0; o_ready = 1; o_busy = 0; o_LED = 0. Reset mid-vector aborts it; no further pulses.
- IDLE: cnt held at 0. i_load=1 at an edge -> sr <= i_taps, cnt <= 0, idx <= 0, state SHIFT.
- SHIFT: cnt increments every cycle, wraps modulo 2^COUNTER_WIDTH. At the edge where cnt == all-ones: o_value <= sr[TOTAL_BITS-1 -: BITS_PER_TAP], sr <= sr << BITS_PER_TAP (zero fill), o_valid <= 1, o_last <= (idx == TOTAL_TAPS-1), idx <= idx+1. At all other edges o_valid <= 0, o_last <= 0.
- Emit with idx == TOTAL_TAPS-1 -> state IDLE on same edge.
- i_load while busy: ignored; no effect on sr, cnt, idx, or output sequence.
- i_taps sampled only on the accepting edge; later changes have no effect.
- No backpressure: consumer must accept every o_valid pulse.

## Timing
- Load accepted at edge E0. Element k appears (o_valid=1) in the cycle after edge E0 + (k+1)*2^COUNTER_WIDTH, lasting exactly one cycle.
- Vector occupancy: TOTAL_TAPS*2^COUNTER_WIDTH cycles from E0 to final emit edge.
- o_ready rises in the same cycle the last element is shown (o_valid=o_last=1); i_load in that cycle is accepted -> back-to-back vectors, next first element 2^COUNTER_WIDTH cycles later, no gap beyond the normal period.
- o_value changes only on emit edges; otherwise holds.
- o_busy/o_ready are complements, registered state.

## Test plan
- Reset: drive i_rst_n low mid-clock with no clock edge -> all outputs at reset values immediately; o_ready=1, o_value=0x00.
- Basic (COUNTER_WIDTH=2): load i_taps=0x010203040506070809 -> o_valid pulses 4,8,...,36 cycles after E0 with o_value 01..09; o_last only with 09; o_ready=1 on cycle 36.
- Ignored load: while busy, pulse i_load with i_taps all 0xFF -> sequence still 01..09, no extra pulses.
- Back-to-back: load 0xA1..A9 asserted exactly in the 09/o_last cycle -> A1 appears 4 cycles later, 18 contiguous-period pulses total.
- Abort: assert reset after element 03 -> no further o_valid; after release, new load 0x11..19 emits 11..19 from index 0.
- Loopback: feed o_value on o_valid into tap shift line with matching pace -> final tap vector equals original i_taps.
